n64rgb_igr_sched: RTL

//  Sequencer between the joybus sniffer and the video-mode/reset resources. Takes

---
 rtl/n64rgb_igr_sched_if.sv | 18 +
 rtl/n64rgb_igr_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/n64rgb_igr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : n64rgb_igr_sched_if
// Brief    : Controller-poll bus from the joybus sniffer into the IGR
//            sequencer: one decoded 16-bit button word plus its 1-cycle
//            poll strobe.
// Revision : 1.0 - initial release
// ============================================================================
interface n64rgb_igr_sched_if;
  logic [15:0] ctrl_word_i;
  logic        ctrl_valid_i;

  // Sniffer side drives the word and strobe.
  modport master (output ctrl_word_i, output ctrl_valid_i);
  // Sequencer side only observes them.
  modport slave  (input  ctrl_word_i, input  ctrl_valid_i);
endinterface
`default_nettype wire

// File: rtl/n64rgb_igr_sched.sv
`default_nettype none
// ============================================================================
// Module   : n64rgb_igr_sched
// Brief    : In-game-routine sequencer. Qualifies controller button combos
//            over several consecutive polls, arbitrates IGR mode commands
//            against the hardware switch toggles for n16bit/nDeBlur, and
//            times the console reset pulse plus the lockout that follows.
// Revision : 1.0 - initial release
// ============================================================================
module n64rgb_igr_sched #(
  parameter int unsigned HOLD_POLLS   = 3,
  parameter logic [23:0] POLL_TIMEOUT = 24'd2000000,
  parameter logic [23:0] RST_CYCLES   = 24'd3200000,
  parameter logic [23:0] LOCK_CYCLES  = 24'd4800000,
  parameter logic [15:0] CMD_RESET    = 16'h080F,
  parameter logic [15:0] CMD_16B_ON   = 16'h081C,
  parameter logic [15:0] CMD_16B_OFF  = 16'h082C,
  parameter logic [15:0] CMD_DBL_OFF  = 16'h084C,
  parameter logic [15:0] CMD_DBL_ON   = 16'h088C
) (
  input  wire logic          VCLK,
  input  wire logic          nRST,
  n64rgb_igr_sched_if.slave  ctrl,
  input  wire logic          en_IGR_Rst_Func,
  input  wire logic          en_IGR_DeBl_16b,
  input  wire logic          n16bit_mode_t,
  input  wire logic          nVIDeBlur_t,
  output logic               n16bit_o,
  output logic               nDeBlur_o,
  output logic               DRV_RST,
  output logic               igr_busy_o
);

  // Timer reload values: a load of N-1 followed by a count down to 0 spans
  // exactly N cycles. A zero parameter saturates instead of wrapping.
  localparam logic [3:0]  c_hold      = 4'(HOLD_POLLS);
  localparam logic [23:0] c_poll_load = (POLL_TIMEOUT == 24'd0) ? 24'd0 : POLL_TIMEOUT - 24'd1;
  localparam logic [23:0] c_rst_load  = (RST_CYCLES   == 24'd0) ? 24'd0 : RST_CYCLES   - 24'd1;
  localparam logic [23:0] c_lock_load = (LOCK_CYCLES  == 24'd0) ? 24'd0 : LOCK_CYCLES  - 24'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_ARMED = 3'd2,
    ST_RST   = 3'd3,
    ST_LOCK  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_hold_cnt, w_hold_cnt_nxt, w_hold_inc;
  logic [15:0] r_cand, w_cand_nxt;
  logic [23:0] r_poll_tmr, w_poll_tmr_nxt, w_poll_dec;
  logic [23:0] r_seq_tmr, w_seq_tmr_nxt, w_seq_dec;
  logic        w_fire;

  logic [15:0] w_word;
  logic        w_valid, w_is_mode, w_match;
  logic        w_set16_vld, w_set16_val, w_setdb_vld, w_setdb_val;

  logic [1:0]  r_sync16, r_syncdb;
  logic        r_hist16, r_histdb;
  logic        w_tog16, w_togdb;
  logic        r_n16bit, r_ndeblur, r_drv_rst, r_busy;

  assign w_word  = ctrl.ctrl_word_i;
  assign w_valid = ctrl.ctrl_valid_i;

  // A strobe matches only if the word is a listed command whose enable is set
  // on that same cycle.
  assign w_is_mode = (w_word == CMD_16B_ON)  || (w_word == CMD_16B_OFF) ||
                     (w_word == CMD_DBL_OFF) || (w_word == CMD_DBL_ON);
  assign w_match   = w_valid && ((en_IGR_Rst_Func && (w_word == CMD_RESET)) ||
                                 (en_IGR_DeBl_16b && w_is_mode));

  assign w_hold_inc = r_hold_cnt + 4'd1;
  assign w_poll_dec = (r_poll_tmr == 24'd0) ? 24'd0 : r_poll_tmr - 24'd1;
  assign w_seq_dec  = (r_seq_tmr  == 24'd0) ? 24'd0 : r_seq_tmr  - 24'd1;

  // A fire always happens on the strobe carrying the command, so the action
  // is decoded from the live word.
  assign w_set16_vld = w_fire && ((w_word == CMD_16B_ON) || (w_word == CMD_16B_OFF));
  assign w_set16_val = (w_word == CMD_16B_OFF);
  assign w_setdb_vld = w_fire && ((w_word == CMD_DBL_OFF) || (w_word == CMD_DBL_ON));
  assign w_setdb_val = (w_word == CMD_DBL_OFF);

  // Switch toggle edge: synced level differs from its one-cycle history.
  assign w_tog16 = r_sync16[1] ^ r_hist16;
  assign w_togdb = r_syncdb[1] ^ r_histdb;

  // Next-state logic for combo qualification, arming and the reset sequence.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_cand_nxt     = r_cand;
    w_poll_tmr_nxt = r_poll_tmr;
    w_seq_tmr_nxt  = r_seq_tmr;
    w_fire         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_cand_nxt     = w_word;
          w_poll_tmr_nxt = c_poll_load;
          if (c_hold <= 4'd1) begin
            w_fire = 1'b1;
          end else begin
            w_hold_cnt_nxt = 4'd1;
            w_state_nxt    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (w_valid) begin
          w_poll_tmr_nxt = c_poll_load;
          if (w_match && (w_word == r_cand)) begin
            if (w_hold_inc >= c_hold) w_fire = 1'b1;
            else                      w_hold_cnt_nxt = w_hold_inc;
          end else if (w_match) begin
            // A different valid combo restarts the qualification.
            w_cand_nxt = w_word;
            if (c_hold <= 4'd1) w_fire = 1'b1;
            else                w_hold_cnt_nxt = 4'd1;
          end else begin
            w_hold_cnt_nxt = 4'd0;
            w_state_nxt    = ST_IDLE;
          end
        end else if (r_poll_tmr == 24'd0) begin
          w_hold_cnt_nxt = 4'd0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_poll_tmr_nxt = w_poll_dec;
        end
      end

      ST_ARMED: begin
        // Combo still held after firing: wait for release so it cannot retrigger.
        if (w_valid) begin
          w_poll_tmr_nxt = c_poll_load;
          if (w_word != r_cand) w_state_nxt = ST_IDLE;
        end else if (r_poll_tmr == 24'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_poll_tmr_nxt = w_poll_dec;
        end
      end

      ST_RST: begin
        if (r_seq_tmr == 24'd0) begin
          w_seq_tmr_nxt = c_lock_load;
          w_state_nxt   = ST_LOCK;
        end else begin
          w_seq_tmr_nxt = w_seq_dec;
        end
      end

      ST_LOCK: begin
        if (r_seq_tmr == 24'd0) w_state_nxt   = ST_IDLE;
        else                    w_seq_tmr_nxt = w_seq_dec;
      end

      default: begin
        w_hold_cnt_nxt = 4'd0;
        w_state_nxt    = ST_IDLE;
      end
    endcase

    if (w_fire) begin
      w_hold_cnt_nxt = 4'd0;
      if (w_word == CMD_RESET) begin
        w_seq_tmr_nxt = c_rst_load;
        w_state_nxt   = ST_RST;
      end else begin
        w_state_nxt   = ST_ARMED;
      end
    end
  end

  // Sequencer state, timers and the registered reset/busy outputs.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 4'd0;
      r_cand     <= 16'd0;
      r_poll_tmr <= 24'd0;
      r_seq_tmr  <= 24'd0;
      r_drv_rst  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_cand     <= w_cand_nxt;
      r_poll_tmr <= w_poll_tmr_nxt;
      r_seq_tmr  <= w_seq_tmr_nxt;
      r_drv_rst  <= (w_state_nxt == ST_RST);
      r_busy     <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_LOCK);
    end
  end

  // Switch synchronisers and mode outputs; a switch toggle beats an IGR
  // command aimed at the same output in the same cycle.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      r_sync16  <= {2{n16bit_mode_t}};
      r_syncdb  <= {2{nVIDeBlur_t}};
      r_hist16  <= n16bit_mode_t;
      r_histdb  <= nVIDeBlur_t;
      r_n16bit  <= n16bit_mode_t;
      r_ndeblur <= nVIDeBlur_t;
    end else begin
      r_sync16  <= {r_sync16[0], n16bit_mode_t};
      r_syncdb  <= {r_syncdb[0], nVIDeBlur_t};
      r_hist16  <= r_sync16[1];
      r_histdb  <= r_syncdb[1];
      if (w_tog16)          r_n16bit  <= r_sync16[1];
      else if (w_set16_vld) r_n16bit  <= w_set16_val;
      if (w_togdb)          r_ndeblur <= r_syncdb[1];
      else if (w_setdb_vld) r_ndeblur <= w_setdb_val;
    end
  end

  assign n16bit_o   = r_n16bit;
  assign nDeBlur_o  = r_ndeblur;
  assign DRV_RST    = r_drv_rst;
  assign igr_busy_o = r_busy;

endmodule
`default_nettype wire
